// File: rtl/mmu_access_arbiter_if.sv
// Bus-op encoding plus the client/MMU signal bundle around mmu_access_arbiter.
// The master modport is the arbiter's view; slave is the clients+MMU side.
package mmu_access_arbiter_pkg;
  typedef enum logic [1:0] {
    BUS_IDLE  = 2'd0,
    BUS_READ  = 2'd1,
    BUS_WRITE = 2'd2
  } bus_op_t;
endpackage

interface mmu_access_arbiter_if #(
  parameter int NUM_CH    = 2,
  parameter int MAX_BYTES = 2,
  parameter int ADDR_W    = 16,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
);
  logic [NUM_CH-1:0]             req_valid;
  logic [NUM_CH-1:0]             req_ready;
  logic [NUM_CH-1:0]             req_write;
  logic [NUM_CH*ADDR_W-1:0]      req_addr;
  logic [NUM_CH*LEN_W-1:0]       req_len;
  logic [NUM_CH*MAX_BYTES*8-1:0] req_wdata;
  logic [NUM_CH-1:0]             rsp_valid;
  logic [MAX_BYTES*8-1:0]        rsp_rdata;
  logic                          busy;
  mmu_access_arbiter_pkg::bus_op_t mmu_bus_op;
  logic [ADDR_W-1:0]             mmu_addr;
  logic [7:0]                    mmu_write_data;
  logic [7:0]                    mmu_read_data;
  logic                          mmu_done;

  modport master (
    input  req_valid, req_write, req_addr, req_len, req_wdata,
    input  mmu_read_data, mmu_done,
    output req_ready, rsp_valid, rsp_rdata, busy,
    output mmu_bus_op, mmu_addr, mmu_write_data
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len, req_wdata,
    output mmu_read_data, mmu_done,
    input  req_ready, rsp_valid, rsp_rdata, busy,
    input  mmu_bus_op, mmu_addr, mmu_write_data
  );
endinterface

// File: rtl/mmu_access_arbiter.sv
// Round-robin arbiter that turns multi-byte client requests into a sequence of
// single-byte MMU operations and returns the assembled little-endian result.
module mmu_access_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int MAX_BYTES = 2,
  parameter int ADDR_W    = 16,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  mmu_access_arbiter_if.master bus
);
  import mmu_access_arbiter_pkg::*;

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DATA_W = MAX_BYTES * 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_RESP
  } state_t;

  state_t              r_state;
  logic [CH_W-1:0]     r_ptr;
  logic [CH_W-1:0]     r_ch;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_acc;
  bus_op_t             r_bus_op;
  logic [ADDR_W-1:0]   r_mmu_addr;
  logic [7:0]          r_mmu_wdata;
  logic [NUM_CH-1:0]   r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;

  logic [ADDR_W-1:0]   w_addr  [NUM_CH];
  logic [LEN_W-1:0]    w_len   [NUM_CH];
  logic [DATA_W-1:0]   w_wdata [NUM_CH];
  logic [CH_W-1:0]     w_cand  [NUM_CH];
  logic                w_grant_any;
  logic [CH_W-1:0]     w_grant_ch;
  logic [NUM_CH-1:0]   w_req_ready;
  logic                w_accept;
  logic [LEN_W-1:0]    w_len_clamp;
  logic [LEN_W-1:0]    w_idx_next;
  logic [CH_W-1:0]     w_ptr_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CH_W:0] w_sum;

      assign w_addr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
      assign w_len[gi]   = bus.req_len[gi*LEN_W +: LEN_W];
      assign w_wdata[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];

      // Candidate at rotation offset gi from the pointer, wrapped modulo NUM_CH.
      assign w_sum       = {1'b0, r_ptr} + (CH_W+1)'(gi);
      assign w_cand[gi]  = (w_sum >= (CH_W+1)'(NUM_CH)) ?
                           CH_W'(w_sum - (CH_W+1)'(NUM_CH)) : CH_W'(w_sum);

      assign w_req_ready[gi] = (r_state == S_IDLE) && w_grant_any &&
                               (w_grant_ch == CH_W'(gi));
    end
  endgenerate

  // Scan from the far end so the lowest rotation offset wins.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_ch  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (bus.req_valid[w_cand[k]]) begin
        w_grant_any = 1'b1;
        w_grant_ch  = w_cand[k];
      end
    end
  end

  assign w_accept    = (r_state == S_IDLE) && w_grant_any;
  assign w_len_clamp = (w_len[w_grant_ch] > LEN_W'(MAX_BYTES)) ?
                       LEN_W'(MAX_BYTES) : w_len[w_grant_ch];
  assign w_idx_next  = r_idx + LEN_W'(1);
  assign w_ptr_next  = (w_grant_ch == CH_W'(NUM_CH - 1)) ? '0 : w_grant_ch + CH_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_ch        <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_acc       <= '0;
      r_bus_op    <= BUS_IDLE;
      r_mmu_addr  <= '0;
      r_mmu_wdata <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ch    <= w_grant_ch;
            r_write <= bus.req_write[w_grant_ch];
            r_addr  <= w_addr[w_grant_ch];
            r_len   <= w_len_clamp;
            r_wdata <= w_wdata[w_grant_ch];
            r_idx   <= '0;
            r_acc   <= '0;
            r_ptr   <= w_ptr_next;
            if (w_len_clamp == '0) begin
              r_state <= S_RESP;
            end else begin
              // Byte 0 goes on the bus in the cycle right after accept.
              r_state     <= S_ISSUE;
              r_bus_op    <= bus.req_write[w_grant_ch] ? BUS_WRITE : BUS_READ;
              r_mmu_addr  <= w_addr[w_grant_ch];
              r_mmu_wdata <= w_wdata[w_grant_ch][7:0];
            end
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mmu_done) begin
            if (!r_write) begin
              r_acc[8*r_idx +: 8] <= bus.mmu_read_data;
            end
            r_bus_op <= BUS_IDLE;
            r_idx    <= w_idx_next;
            r_state  <= (w_idx_next == r_len) ? S_RESP : S_GAP;
          end
        end
        S_GAP: begin
          r_state     <= S_ISSUE;
          r_bus_op    <= r_write ? BUS_WRITE : BUS_READ;
          r_mmu_addr  <= r_addr + ADDR_W'(r_idx);
          r_mmu_wdata <= r_wdata[8*r_idx +: 8];
        end
        S_RESP: begin
          r_rsp_valid[r_ch] <= 1'b1;
          r_rsp_rdata       <= r_acc;
          r_state           <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready      = w_req_ready;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_rdata      = r_rsp_rdata;
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.mmu_bus_op     = r_bus_op;
  assign bus.mmu_addr       = r_mmu_addr;
  assign bus.mmu_write_data = r_mmu_wdata;
endmodule
